// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multicycle CPU controller
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_FAULT    = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_MEMDATA   = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    // States that hold a memory request open and are guarded by the timeout.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating mem_ready wait counter with timeout flag
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic mem_ready_i,
    output logic expired_o
);

    localparam int unsigned CW  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   LIMIT   = CW1'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;

    // Leaving a wait state always coincides with mem_ready (or FAULT), so
    // clearing on mem_ready also clears on entry to the next wait state.
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || mem_ready_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // mem_ready wins a tie with the final allowed wait cycle.
    assign cnt_inc   = {1'b0, cnt_q} + CW1'(1);
    assign expired_o = active_i && !mem_ready_i && (cnt_inc >= LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V style control FSM with memory timeout
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        instr_done,
    output logic        fault,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e     state_q, state_d;
    logic       wait_expired;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign funct3            = instruction[14:12];
    assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};
    assign state             = state_q;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .active_i   (is_mem_wait(state_q)),
        .mem_ready_i(mem_ready),
        .expired_o  (wait_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        instr_done = 1'b0;
        fault      = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                adr_src    = ADR_PC;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready)         state_d = S_DECODE;
                else if (wait_expired) state_d = S_FAULT;
            end
            S_DECODE: begin
                // ALU precomputes the branch target from oldPC + imm.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = ADR_ALUOUT;
                result_src = RES_ALUOUT;
                if (mem_ready)         state_d = S_MEMWB;
                else if (wait_expired) state_d = S_FAULT;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                adr_src    = ADR_ALUOUT;
                instr_done = mem_ready;
                if (mem_ready)         state_d = S_FETCH;
                else if (wait_expired) state_d = S_FAULT;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                // addi must add even when imm[10] (instruction[30]) is set.
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = (funct3 == 3'b000) ? ALUOP_ADD : ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized and directed bench with plan-queue reference model
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, pc_write, ir_write, reg_write, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic        instr_done, fault, illegal;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .instr_done(instr_done),
        .fault(fault), .illegal(illegal), .state(state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic supported(input logic [6:0] op);
        return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
    endfunction

    function automatic int lat_of(input logic [6:0] op);
        case (op)
            7'h03:   return 5;
            7'h23:   return 4;
            7'h33:   return 4;
            7'h13:   return 4;
            7'h63:   return 3;
            7'h6F:   return 4;
            default: return 0;
        endcase
    endfunction

    // Output vector: {mem_req,mem_we,pc_write,ir_write,reg_write,adr_src,a,b,op,res,done,fault,illegal,state}
    function automatic logic [20:0] exp_vec(input state_e st, input logic rdy, input logic zr,
                                            input logic [31:0] ins);
        logic mreq = 0, we = 0, pcw = 0, irw = 0, rw = 0, adr = 0, done = 0, flt = 0, ill = 0;
        logic [1:0] a = 0, b = 0, op = 0, res = 0;
        case (st)
            S_FETCH:    begin mreq = 1; b = 2; res = 2; irw = rdy; pcw = rdy; end
            S_DECODE:   begin a = 1; b = 1; ill = !supported(ins[6:0]); end
            S_MEMADR:   begin a = 2; b = 1; end
            S_MEMREAD:  begin mreq = 1; adr = 1; end
            S_MEMWB:    begin res = 1; rw = 1; done = 1; end
            S_MEMWRITE: begin mreq = 1; we = 1; adr = 1; done = rdy; end
            S_EXECR:    begin a = 2; op = 2; end
            S_EXECI:    begin a = 2; b = 1; op = (ins[14:12] == 3'd0) ? 2'd0 : 2'd2; end
            S_ALUWB:    begin rw = 1; done = 1; end
            S_BEQ:      begin a = 2; op = 1; pcw = zr; done = 1; end
            S_JAL:      begin a = 1; b = 2; pcw = 1; end
            S_FAULT:    flt = 1;
            default:    ;
        endcase
        return {mreq, we, pcw, irw, rw, adr, a, b, op, res, done, flt, ill, 4'(st)};
    endfunction

    logic [20:0] dut_vec;
    assign dut_vec = {mem_req, mem_we, pc_write, ir_write, reg_write, adr_src, alu_src_a,
                      alu_src_b, alu_op, result_src, instr_done, fault, illegal, state};

    // Reference model: on each completed fetch, the instruction class expands into
    // the list of states it must walk through; wait states drain on mem_ready.
    state_e     m_state = S_IDLE;
    state_e     m_next  = S_IDLE;
    state_e     plan[$];
    int         m_wait = 0;
    int         cyc = 0, t_start = 0, waits = 0;
    logic [6:0] cur_op = 7'h0;
    logic [20:0] ev;

    task automatic build_plan(input logic [6:0] op);
        plan.delete();
        plan.push_back(S_DECODE);
        case (op)
            7'h03: begin plan.push_back(S_MEMADR); plan.push_back(S_MEMREAD); plan.push_back(S_MEMWB); end
            7'h23: begin plan.push_back(S_MEMADR); plan.push_back(S_MEMWRITE); end
            7'h33: begin plan.push_back(S_EXECR); plan.push_back(S_ALUWB); end
            7'h13: begin plan.push_back(S_EXECI); plan.push_back(S_ALUWB); end
            7'h63: plan.push_back(S_BEQ);
            7'h6F: begin plan.push_back(S_JAL); plan.push_back(S_ALUWB); end
            default: ;
        endcase
        plan.push_back(S_FETCH);
    endtask

    always @(negedge clk) begin
        cyc++;
        ev = exp_vec(m_state, mem_ready, zero, instruction);
        check("outputs", 32'(dut_vec), 32'(ev));
        if (rst_n && ev[6] && instr_done)
            check("latency", 32'(cyc - t_start + 1 - waits), 32'(lat_of(cur_op)));
        if (rst_n && is_mem_wait(m_state) && !mem_ready) waits++;

        if (!rst_n) begin
            m_next = S_IDLE;
            plan.delete();
            m_wait = 0;
        end else if (m_state == S_IDLE) begin
            plan.delete();
            m_wait = 0;
            m_next = S_FETCH;
        end else if (m_state == S_FAULT) begin
            m_next = S_FAULT;
        end else if (is_mem_wait(m_state)) begin
            if (mem_ready) begin
                if (m_state == S_FETCH) begin
                    cur_op = instruction[6:0];
                    build_plan(cur_op);
                end
                m_next = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
                m_wait = 0;
            end else begin
                m_wait++;
                m_next = (m_wait >= TMO) ? S_FAULT : m_state;
            end
        end else begin
            m_next = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
        end

        if (rst_n && m_next == S_FETCH && m_state != S_FETCH) begin
            t_start = cyc + 1;
            waits   = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_state <= S_IDLE;
        else        m_state <= m_next;
    end

    task automatic step(input logic rdy, input logic zr);
        @(posedge clk); #1;
        mem_ready = rdy;
        zero      = zr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[6:0] = 7'h03;
            1: r[6:0] = 7'h23;
            2: r[6:0] = 7'h33;
            3: r[6:0] = 7'h13;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h6F;
            default: begin
                r[6:0] = 7'h7F;
                while (supported(r[6:0])) r[6:0] = 7'($urandom);
            end
        endcase
        return r;
    endfunction

    state_e add_seq[5] = '{S_IDLE, S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
    logic [31:0] execi_ins[2] = '{32'hC000_0093, 32'h4030_D093};
    logic [1:0]  execi_op[2]  = '{2'd0, 2'd2};

    initial begin
        int mreq_cycles;

        // add x3,x1,x2 with no memory wait
        instruction = 32'h0020_81B3;
        do_reset();
        check("reset_outputs", 32'(dut_vec), 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1'b1, 1'b0);
            check("add_state", 32'(state), 32'(add_seq[i]));
        end
        check("add_reg_write", 32'(reg_write), 32'h1);
        check("add_instr_done", 32'(instr_done), 32'h1);

        // lw with three wait cycles in MEMREAD
        instruction = 32'h0000_A103;
        do_reset();
        step(1'b1, 1'b0);
        check("lw_fetch_ir_write", 32'(ir_write), 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        mreq_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 1'b0);
            if (mem_req && state == 4'(S_MEMREAD)) mreq_cycles++;
            if (i == 3) check("lw_memread_ir_write", 32'(ir_write), 32'h0);
        end
        check("lw_mem_req_cycles", 32'(mreq_cycles), 32'd4);
        step(1'b1, 1'b0);
        check("lw_memwb_state", 32'(state), 32'(S_MEMWB));

        // beq taken and not taken
        instruction = 32'h0020_8063;
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'(z));
            check("beq_state", 32'(state), 32'(S_BEQ));
            check("beq_pc_write", 32'(pc_write), 32'(z));
            step(1'b1, 1'b0);
            check("beq_next_fetch", 32'(state), 32'(S_FETCH));
        end

        // addi with imm bit 30 set, then srai-like funct3=101
        for (int k = 0; k < 2; k++) begin
            instruction = execi_ins[k];
            do_reset();
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            check("execi_state", 32'(state), 32'(S_EXECI));
            check("execi_alu_op", 32'(alu_op), 32'(execi_op[k]));
        end

        // unsupported opcode
        instruction = 32'h0000_007F;
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("illegal_pulse", 32'(illegal), 32'h1);
        check("illegal_no_reg_write", 32'(reg_write), 32'h0);
        step(1'b1, 1'b0);
        check("illegal_then_fetch", 32'(state), 32'(S_FETCH));
        check("illegal_one_cycle", 32'(illegal), 32'h0);

        // reset mid-request drops mem_req without a clock edge
        do_reset();
        step(1'b0, 1'b0);
        check("async_pre_mem_req", 32'(mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mem_req_drop", 32'(mem_req), 32'h0);
        check("async_state_idle", 32'(state), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        // timeout: four low cycles fault, ready on the fourth wins
        instruction = 32'h0020_81B3;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("tmo_still_fetch", 32'(state), 32'(S_FETCH));
        step(1'b0, 1'b0);
        check("tmo_fault_state", 32'(state), 32'(S_FAULT));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("tmo_fault_sticky", 32'(fault), 32'h1);
        check("tmo_fault_no_req", 32'(mem_req), 32'h0);
        do_reset();
        check("tmo_reset_clears", 32'(fault), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("tmo_ready_wins_irw", 32'(ir_write), 32'h1);
        step(1'b1, 1'b0);
        check("tmo_ready_wins_decode", 32'(state), 32'(S_DECODE));

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ((m_state == S_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0)
                rst_n = 1'b0;
            if (m_state == S_FETCH || m_state == S_IDLE) instruction = rand_instr();
            mem_ready = ($urandom_range(0, 99) < 65);
            zero      = 1'($urandom_range(0, 1));
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
